// File: rtl/dec_gray_track.sv
// 3-bit Gray-code decoder with step-direction tracking and a saturating
// illegal-step counter, behind a single-entry valid/ready pipeline register.
module dec_gray_track #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           gray,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           onehot,
  output logic [2:0]           index,
  output logic [1:0]           dir,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 clr_err
);

  typedef struct packed {
    logic [7:0] onehot;
    logic [2:0] index;
    logic [1:0] dir;
  } res_t;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

  res_t       res_q, res_d;
  logic [2:0] prev_idx, new_idx, d;
  logic       prev_vld, acc, illegal;

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  assign new_idx = {gray[2], gray[2] ^ gray[1], ^gray};
  assign d       = new_idx - prev_idx;

  always_comb begin
    res_d.index  = new_idx;
    res_d.onehot = 8'b1 << new_idx;
    if (!prev_vld) begin
      res_d.dir = 2'b00;
    end else begin
      case (d)
        3'd0:    res_d.dir = 2'b00;
        3'd1:    res_d.dir = 2'b01;
        3'd7:    res_d.dir = 2'b10;
        default: res_d.dir = 2'b11;
      endcase
    end
  end

  assign illegal = acc && (res_d.dir == 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      out_valid <= 1'b0;
      prev_idx  <= 3'd0;
      prev_vld  <= 1'b0;
    end else if (acc) begin
      res_q     <= res_d;
      out_valid <= 1'b1;
      prev_idx  <= new_idx;
      prev_vld  <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A clear coinciding with an illegal accept keeps that one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (clr_err)
      err_cnt <= illegal ? ERR_ONE : '0;
    else if (illegal && err_cnt != ERR_MAX)
      err_cnt <= err_cnt + ERR_ONE;
  end

  assign onehot = res_q.onehot;
  assign index  = res_q.index;
  assign dir    = res_q.dir;

endmodule
